reg_bank_param: RTL
===================

Name: reg_bank_param

Overview:
- Parametrised successor to the I2C-facing register memory: N_CH analog channels (control and ADC registers), N_DAC double-buffered DAC registers, a STATUS register and a CMD register.
- Sits between the I2C slave register interface and the analog block.
- Runs on a single clock edge; no negedge enable logic.
- Adds a read-valid handshake, ADC sample-valid capture with overrun detection, access-error reporting and an atomic DAC commit with settle hold-off.

Parameters:
- DATA_W, 8, register and data width; must be >= N_CH+3.
- N_CH, 3, analog channel count; gives N_CH control regs and N_CH read-only ADC regs.
- N_DAC, 31, number of DAC registers.
- DAC_SETTLE, 4, clock cycles after a commit during which a further commit is held pending; must be >= 1.
- AUTO_COMMIT, 0, when 1 a DAC shadow write drives dac_out directly and CMD bit0 is ignored.
- ADDR_W, clog2(2*N_CH+N_DAC+2), address width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- adc_in  in  N_CH*DATA_W  channel i ADC sample in slice [i*DATA_W +: DATA_W].
- adc_valid  in  N_CH  one-cycle sample strobe per channel.
- dac_out  out  N_DAC*DATA_W  active DAC codes.
- dac_update  out  1  one-cycle pulse when dac_out changes due to a commit.
- cs_control  out  N_CH*3  current-source select per channel.
- cp_reset, timer_en, timer_fen, amp_en  out  N_CH each  per-channel control bits.
- reg_addr  in  ADDR_W  register address from I2C.
- reg_wdata  in  DATA_W  write data.
- reg_write  in  1  single-cycle write strobe.
- reg_read  in  1  single-cycle read strobe.
- reg_rdata  out  DATA_W  read data.
- reg_rvalid  out  1  read data valid pulse.
- reg_err  out  1  one-cycle pulse on a rejected access.

Behaviour:
- Address map:
  - CTRL[i] at i.
  - ADC[i] at N_CH+i (read-only).
  - DAC shadow[j] at 2*N_CH+j.
  - STATUS at A_ST=2*N_CH+N_DAC (read-only).
  - CMD at A_ST+1 (write-only; reads return 0).
- Reset (rst high, async): all registers, shadows, dac_out, control outputs, reg_rdata, reg_rvalid, reg_err, dac_update and status flags go to 0; FSM goes to IDLE.
- CTRL layout, bit 6..0: amp_en, timer_en, timer_fen, cp_reset, cs_control[2:0]. Bits above 6 read as 0.
  - A CTRL write is visible on the control outputs on the cycle after the write strobe (1-cycle latency).
- Read: reg_read with a legal address gives reg_rdata and reg_rvalid=1 the next cycle.
  - reg_rdata holds its value until the next read.
  - reg_rvalid is a 1-cycle pulse.
- Rejected accesses (no state change; reg_err pulses the next cycle; STATUS.err sticky bit0 is set):
  - reg_write and reg_read both high.
  - Address > A_ST+1.
  - Write to an ADC or STATUS address.
  - A read of a rejected address gives no reg_rvalid.
- ADC capture: adc_valid[i] loads ADC[i] and sets new[i].
  - If new[i] is already set when adc_valid[i] arrives, STATUS.ovr[i] (bit 3+i) sets sticky.
  - Reading ADC[i] clears new[i].
  - If the read and adc_valid[i] occur in the same cycle, the read returns the old value and new[i] stays set.
- STATUS bits:
  - [0] err.
  - [1] settle busy.
  - [2] commit pending.
  - [3+i] ovr[i].
  - Remaining bits read 0.
- CMD register:
  - bit0=1 requests a DAC commit.
  - bit1=1 clears err and all ovr bits. A clear in the same cycle as a new error/overrun leaves the flag set.
  - Bits are self-clearing and not stored.
- Commit FSM (AUTO_COMMIT=0):
  - IDLE: a commit request copies all shadows to dac_out on the next cycle, pulses dac_update, then goes to SETTLE with the counter loaded to DAC_SETTLE-1.
  - SETTLE: counts down. A commit request here sets pending; a second request while pending is absorbed. At count 0, go to IDLE if pending is clear, otherwise commit the current shadows, clear pending and reload SETTLE.
  - Shadow writes are always accepted; dac_out changes only on commit.
- AUTO_COMMIT=1: a shadow write updates that dac_out slice 1 cycle later, with no dac_update pulse; the FSM stays IDLE.
- Reset mid-SETTLE: returns to IDLE, pending is dropped and dac_out goes to 0.

Decomposition:
- Package reg_bank_pkg holds:
  - CTRL bit-position constants.
  - STATUS bit constants.
  - CMD bit constants.
  - Address-offset functions of N_CH/N_DAC.
  - commit_state_e enum {IDLE, SETTLE}.
- Sub-module dac_commit_ctrl contains the commit FSM, settle counter, pending flag and dac_update generation.

Test Plan:
- Reset, then read STATUS -> reg_rdata=0x00, reg_rvalid high exactly one cycle after reg_read.
- Write CTRL[1]=0x55 -> next cycle amp_en[1]=1, timer_en[1]=0, timer_fen[1]=1, cp_reset[1]=0, cs_control[1]=3'b101; read back gives 0x55.
- adc_valid[0] with 0xA3, then adc_valid[0] with 0x17 without a read -> ADC[0] reads 0x17, STATUS=0x08; CMD write 0x02 -> STATUS=0x00.
- Write to ADC[2], write to address A_ST+2, and reg_read+reg_write together -> each gives one reg_err pulse, no register change, STATUS bit0=1.
- Shadow[0]=0x10, CMD=0x01 -> dac_out[0]=0x10 with dac_update pulse. Shadow[0]=0x20, CMD=0x01 during SETTLE -> STATUS bit2=1, dac_out stays 0x10 until settle expiry, then 0x20 with a second pulse.
- AUTO_COMMIT=1: shadow[30]=0xFF -> dac_out[30]=0xFF one cycle later, no dac_update; assert rst mid-SETTLE (AUTO_COMMIT=0) -> dac_out all 0, FSM IDLE.

Source files
------------

// File: rtl/reg_bank_param_pkg.sv
// Shared constants, address helpers and commit FSM state type for the
// parametrised analog register bank.
package reg_bank_pkg;

    localparam int CTRL_CS_LSB    = 0;
    localparam int CTRL_CS_W      = 3;
    localparam int CTRL_CP_RESET  = 3;
    localparam int CTRL_TIMER_FEN = 4;
    localparam int CTRL_TIMER_EN  = 5;
    localparam int CTRL_AMP_EN    = 6;
    localparam int CTRL_W         = 7;

    localparam int ST_ERR     = 0;
    localparam int ST_BUSY    = 1;
    localparam int ST_PEND    = 2;
    localparam int ST_OVR_LSB = 3;

    localparam int CMD_COMMIT = 0;
    localparam int CMD_CLEAR  = 1;

    function automatic int ctrl_addr(input int idx);
        return idx;
    endfunction

    function automatic int adc_addr(input int n_ch, input int idx);
        return n_ch + idx;
    endfunction

    function automatic int dac_addr(input int n_ch, input int idx);
        return 2 * n_ch + idx;
    endfunction

    function automatic int status_addr(input int n_ch, input int n_dac);
        return 2 * n_ch + n_dac;
    endfunction

    function automatic int cmd_addr(input int n_ch, input int n_dac);
        return 2 * n_ch + n_dac + 1;
    endfunction

    typedef enum logic {
        IDLE,
        SETTLE
    } commit_state_e;

endpackage

// File: rtl/reg_bank_param_if.sv
// Register access bus between the I2C slave (master side) and the register bank.
interface reg_bank_param_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_write;
    logic              reg_read;
    logic [DATA_W-1:0] reg_rdata;
    logic              reg_rvalid;
    logic              reg_err;

    modport master (
        output reg_addr, reg_wdata, reg_write, reg_read,
        input  reg_rdata, reg_rvalid, reg_err
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_write, reg_read,
        output reg_rdata, reg_rvalid, reg_err
    );
endinterface

// File: rtl/reg_bank_param_dac_commit_ctrl.sv
// DAC commit sequencer: copies shadows to the active DAC codes atomically and
// holds off further commits for a settle window, remembering one pending request.
module dac_commit_ctrl
    import reg_bank_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int N_DAC       = 31,
    parameter int DAC_SETTLE  = 4,
    parameter int AUTO_COMMIT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_commit_req,
    input  logic [N_DAC*DATA_W-1:0] i_shadow,
    input  logic [N_DAC-1:0]        i_shadow_we,
    input  logic [DATA_W-1:0]       i_wdata,
    output logic [N_DAC*DATA_W-1:0] o_dac_out,
    output logic                    o_dac_update,
    output logic                    o_busy,
    output logic                    o_pending
);

    localparam int CNT_W = (DAC_SETTLE > 1) ? $clog2(DAC_SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DAC_SETTLE - 1);

    commit_state_e           r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_pending;
    logic                    r_update;
    logic [N_DAC*DATA_W-1:0] r_dac_out;

    // A request arriving on the final settle cycle is folded into the recommit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_update  <= 1'b0;
            r_dac_out <= '0;
        end else begin
            r_update <= 1'b0;
            if (AUTO_COMMIT != 0) begin
                for (int j = 0; j < N_DAC; j++) begin
                    if (i_shadow_we[j]) begin
                        r_dac_out[j*DATA_W +: DATA_W] <= i_wdata;
                    end
                end
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_pending <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_commit_req) begin
                            r_dac_out <= i_shadow;
                            r_update  <= 1'b1;
                            r_state   <= SETTLE;
                            r_cnt     <= CNT_RELOAD;
                        end
                    end
                    SETTLE: begin
                        if (r_cnt == '0) begin
                            if (r_pending || i_commit_req) begin
                                r_dac_out <= i_shadow;
                                r_update  <= 1'b1;
                                r_pending <= 1'b0;
                                r_cnt     <= CNT_RELOAD;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                            if (i_commit_req) begin
                                r_pending <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_dac_out    = r_dac_out;
    assign o_dac_update = r_update;
    assign o_busy       = (r_state == SETTLE);
    assign o_pending    = r_pending;

endmodule

// File: rtl/reg_bank_param.sv
// Register bank between the I2C register interface and the analog block:
// channel control, ADC capture with overrun flags, DAC shadows and status/command.
module reg_bank_param
    import reg_bank_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int N_CH        = 3,
    parameter int N_DAC       = 31,
    parameter int DAC_SETTLE  = 4,
    parameter int AUTO_COMMIT = 0,
    parameter int ADDR_W      = $clog2(2*N_CH + N_DAC + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    reg_bank_param_if.slave         bus,
    input  logic [N_CH*DATA_W-1:0]  i_adc_in,
    input  logic [N_CH-1:0]         i_adc_valid,
    output logic [N_DAC*DATA_W-1:0] o_dac_out,
    output logic                    o_dac_update,
    output logic [N_CH*3-1:0]       o_cs_control,
    output logic [N_CH-1:0]         o_cp_reset,
    output logic [N_CH-1:0]         o_timer_en,
    output logic [N_CH-1:0]         o_timer_fen,
    output logic [N_CH-1:0]         o_amp_en
);

    localparam logic [ADDR_W-1:0] A_ADC = ADDR_W'(adc_addr(N_CH, 0));
    localparam logic [ADDR_W-1:0] A_DAC = ADDR_W'(dac_addr(N_CH, 0));
    localparam logic [ADDR_W-1:0] A_ST  = ADDR_W'(status_addr(N_CH, N_DAC));
    localparam logic [ADDR_W-1:0] A_CMD = ADDR_W'(cmd_addr(N_CH, N_DAC));

    logic [CTRL_W-1:0]       r_ctrl [N_CH];
    logic [DATA_W-1:0]       r_adc  [N_CH];
    logic [N_CH-1:0]         r_new;
    logic [N_CH-1:0]         r_ovr;
    logic                    r_err_flag;
    logic [N_DAC*DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_rvalid;
    logic                    r_err;

    logic              w_is_adc, w_is_st, w_is_cmd, w_in_map;
    logic              w_reject, w_wr_ok, w_rd_ok;
    logic              w_commit_req, w_clear;
    logic              w_busy, w_pending;
    logic [N_CH-1:0]   w_ctrl_we, w_adc_rd;
    logic [N_DAC-1:0]  w_dac_we;
    logic [DATA_W-1:0] w_rd_mux, w_status;

    assign w_is_adc = (bus.reg_addr >= A_ADC) && (bus.reg_addr < A_DAC);
    assign w_is_st  = (bus.reg_addr == A_ST);
    assign w_is_cmd = (bus.reg_addr == A_CMD);
    assign w_in_map = (bus.reg_addr <= A_CMD);

    assign w_reject = (bus.reg_write && bus.reg_read) || ((bus.reg_write || bus.reg_read) && !w_in_map)
                    || (bus.reg_write && (w_is_adc || w_is_st));
    assign w_wr_ok  = bus.reg_write && !w_reject;
    assign w_rd_ok  = bus.reg_read && !w_reject;

    assign w_commit_req = w_wr_ok && w_is_cmd && bus.reg_wdata[CMD_COMMIT];
    assign w_clear      = w_wr_ok && w_is_cmd && bus.reg_wdata[CMD_CLEAR];

    always_comb begin
        w_status = '0;
        w_status[ST_ERR]  = r_err_flag;
        w_status[ST_BUSY] = w_busy;
        w_status[ST_PEND] = w_pending;
        w_status[ST_OVR_LSB +: N_CH] = r_ovr;
    end

    // Address decode; CMD and unmatched addresses read back as zero.
    always_comb begin
        w_ctrl_we = '0;
        w_adc_rd  = '0;
        w_dac_we  = '0;
        w_rd_mux  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.reg_addr == ADDR_W'(ctrl_addr(i))) begin
                w_ctrl_we[i] = w_wr_ok;
                w_rd_mux     = DATA_W'(r_ctrl[i]);
            end
            if (bus.reg_addr == ADDR_W'(adc_addr(N_CH, i))) begin
                w_adc_rd[i] = w_rd_ok;
                w_rd_mux    = r_adc[i];
            end
        end
        for (int j = 0; j < N_DAC; j++) begin
            if (bus.reg_addr == ADDR_W'(dac_addr(N_CH, j))) begin
                w_dac_we[j] = w_wr_ok;
                w_rd_mux    = r_shadow[j*DATA_W +: DATA_W];
            end
        end
        if (w_is_st) begin
            w_rd_mux = w_status;
        end
    end

    // A sample strobe wins over a same-cycle read, so the new flag survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_ctrl[i] <= '0;
                r_adc[i]  <= '0;
            end
            r_new      <= '0;
            r_ovr      <= '0;
            r_err_flag <= 1'b0;
            r_shadow   <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= w_rd_ok;
            r_err    <= w_reject;
            if (w_rd_ok) begin
                r_rdata <= w_rd_mux;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (w_ctrl_we[i]) begin
                    r_ctrl[i] <= bus.reg_wdata[CTRL_W-1:0];
                end
                if (i_adc_valid[i]) begin
                    r_adc[i] <= i_adc_in[i*DATA_W +: DATA_W];
                    r_new[i] <= 1'b1;
                end else if (w_adc_rd[i]) begin
                    r_new[i] <= 1'b0;
                end
                if (i_adc_valid[i] && r_new[i]) begin
                    r_ovr[i] <= 1'b1;
                end else if (w_clear) begin
                    r_ovr[i] <= 1'b0;
                end
            end
            if (w_reject) begin
                r_err_flag <= 1'b1;
            end else if (w_clear) begin
                r_err_flag <= 1'b0;
            end
            for (int j = 0; j < N_DAC; j++) begin
                if (w_dac_we[j]) begin
                    r_shadow[j*DATA_W +: DATA_W] <= bus.reg_wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ctrl_out
        assign o_cs_control[g*3 +: 3] = r_ctrl[g][CTRL_CS_LSB +: CTRL_CS_W];
        assign o_cp_reset[g]          = r_ctrl[g][CTRL_CP_RESET];
        assign o_timer_fen[g]         = r_ctrl[g][CTRL_TIMER_FEN];
        assign o_timer_en[g]          = r_ctrl[g][CTRL_TIMER_EN];
        assign o_amp_en[g]            = r_ctrl[g][CTRL_AMP_EN];
    end

    dac_commit_ctrl #(
        .DATA_W      (DATA_W),
        .N_DAC       (N_DAC),
        .DAC_SETTLE  (DAC_SETTLE),
        .AUTO_COMMIT (AUTO_COMMIT)
    ) u_commit (
        .clk          (clk),
        .rst          (rst),
        .i_commit_req (w_commit_req),
        .i_shadow     (r_shadow),
        .i_shadow_we  (w_dac_we),
        .i_wdata      (bus.reg_wdata),
        .o_dac_out    (o_dac_out),
        .o_dac_update (o_dac_update),
        .o_busy       (w_busy),
        .o_pending    (w_pending)
    );

    assign bus.reg_rdata  = r_rdata;
    assign bus.reg_rvalid = r_rvalid;
    assign bus.reg_err    = r_err;

endmodule
